// File: rtl/mvm_pkg.sv
// Shared definitions for the 8x8 streaming signed matrix-vector multiplier.
package mvm_pkg;

  localparam int unsigned M     = 8;
  localparam int unsigned P     = 1;
  localparam int unsigned T     = 16;
  localparam int unsigned L     = 1;
  localparam int unsigned OUT_W = 2 * T;
  localparam int unsigned NE    = M * M;
  localparam int unsigned IDX_W = $clog2(NE);
  localparam int unsigned VEC_W = $clog2(M);
  // Counter spans the compute phase: NE issue cycles plus pipeline drain.
  localparam int unsigned CNT_W = $clog2(NE + L + 2);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_X,
    COMPUTE,
    DONE,
    OUTPUT
  } state_t;

endpackage

// File: rtl/mvm_8_1_16_1_core_if.sv
// Load/start control and serial data bus of the matrix-vector multiplier.
interface mvm_8_1_16_1_core_if;
  import mvm_pkg::*;

  logic                    loadMatrix;
  logic                    loadVector;
  logic                    start;
  logic                    done;
  logic signed [T-1:0]     data_in;
  logic signed [OUT_W-1:0] data_out;

  modport master (
    output loadMatrix, loadVector, start, data_in,
    input  done, data_out
  );

  modport slave (
    input  loadMatrix, loadVector, start, data_in,
    output done, data_out
  );

endinterface

// File: rtl/mvm_mac.sv
// Signed TxT multiply with L register stages feeding a 2T-bit accumulator.
// Define MVM_SATURATE_EN for a saturating accumulator instead of wrap-around.
module mvm_mac #(
  parameter int unsigned T = 16,
  parameter int unsigned L = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [T-1:0]   a,
  input  logic signed [T-1:0]   b,
  input  logic                  valid,
  input  logic                  clr,
  input  logic                  last,
  output logic signed [2*T-1:0] result,
  output logic                  result_valid
);

  logic signed [2*T-1:0] a_ext, b_ext;
  logic signed [2*T-1:0] prod_q [L];
  logic                  valid_q [L];
  logic                  clr_q   [L];
  logic                  last_q  [L];
  logic signed [2*T-1:0] acc, base, sum;

  assign a_ext = {{T{a[T-1]}}, a};
  assign b_ext = {{T{b[T-1]}}, b};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < L; i++) begin
        prod_q[i]  <= '0;
        valid_q[i] <= 1'b0;
        clr_q[i]   <= 1'b0;
        last_q[i]  <= 1'b0;
      end
      acc <= '0;
    end else begin
      prod_q[0]  <= a_ext * b_ext;
      valid_q[0] <= valid;
      clr_q[0]   <= clr;
      last_q[0]  <= last;
      for (int unsigned i = 1; i < L; i++) begin
        prod_q[i]  <= prod_q[i-1];
        valid_q[i] <= valid_q[i-1];
        clr_q[i]   <= clr_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
      if (valid_q[L-1]) acc <= sum;
    end
  end

  assign base = clr_q[L-1] ? '0 : acc;

`ifdef MVM_SATURATE_EN
  logic signed [2*T:0] wide;
  always_comb begin
    wide = {base[2*T-1], base} + {prod_q[L-1][2*T-1], prod_q[L-1]};
    sum  = wide[2*T-1:0];
    if (wide[2*T] != wide[2*T-1])
      sum = wide[2*T] ? {1'b1, {(2*T-1){1'b0}}} : {1'b0, {(2*T-1){1'b1}}};
  end
`else
  assign sum = base + prod_q[L-1];
`endif

  // The completed row sum is taken straight from the adder, not from acc.
  assign result       = sum;
  assign result_valid = valid_q[L-1] & last_q[L-1];

endmodule

// File: rtl/mvm_8_1_16_1_core.sv
// Streaming y = A*x core: serial A/x load, single-MAC compute, serial result output.
// Optional MVM_SATURATE_EN selects a saturating accumulator inside mvm_mac.
module mvm_8_1_16_1_core
  import mvm_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  mvm_8_1_16_1_core_if.slave  bus
);

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic                    start_acc;

  logic signed [T-1:0]     a_mem [NE];
  logic signed [T-1:0]     x_mem [M];
  logic signed [OUT_W-1:0] y_mem [M];
  logic [VEC_W-1:0]        wptr;
  logic signed [OUT_W-1:0] dout_q;

  logic                    issue;
  logic [VEC_W-1:0]        col;
  logic signed [OUT_W-1:0] mac_res;
  logic                    mac_valid;

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    start_acc  = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (bus.loadMatrix)      state_next = LOAD_A;
        else if (bus.loadVector) state_next = LOAD_X;
        else if (bus.start) begin
          state_next = COMPUTE;
          start_acc  = 1'b1;
        end
      end
      LOAD_A: if (cnt == CNT_W'(NE - 1)) begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      LOAD_X: if (cnt == CNT_W'(M - 1)) begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      COMPUTE: if (cnt == CNT_W'(NE + L)) begin
        state_next = DONE;
        cnt_next   = '0;
      end
      // DONE already loads y[0]; OUTPUT then counts 1..M.
      DONE: begin
        state_next = OUTPUT;
        cnt_next   = CNT_W'(1);
      end
      OUTPUT: if (cnt == CNT_W'(M)) begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign issue = (state == COMPUTE) && (cnt < CNT_W'(NE));
  assign col   = cnt[VEC_W-1:0];

  mvm_mac #(
    .T (T),
    .L (L)
  ) u_mac (
    .clk          (clk),
    .reset        (reset),
    .a            (a_mem[cnt[IDX_W-1:0]]),
    .b            (x_mem[col]),
    .valid        (issue),
    .clr          (issue && (col == '0)),
    .last         (issue && (col == '1)),
    .result       (mac_res),
    .result_valid (mac_valid)
  );

  // Operand storage survives reset so a partial load keeps its written words.
  always_ff @(posedge clk) begin
    if (!reset && state == LOAD_A) a_mem[cnt[IDX_W-1:0]] <= bus.data_in;
    if (!reset && state == LOAD_X) x_mem[cnt[VEC_W-1:0]] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      wptr   <= '0;
      dout_q <= '0;
      for (int unsigned i = 0; i < M; i++) y_mem[i] <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (start_acc) begin
        wptr <= '0;
      end else if (mac_valid) begin
        y_mem[wptr] <= mac_res;
        wptr        <= wptr + 1'b1;
      end
      if (state == DONE)
        dout_q <= y_mem[0];
      else if (state == OUTPUT && cnt < CNT_W'(M))
        dout_q <= y_mem[cnt[VEC_W-1:0]];
    end
  end

  assign bus.done     = (state == DONE);
  assign bus.data_out = dout_q;

endmodule

// File: tb/tb_mvm_8_1_16_1_core.sv
// Directed self-checking bench for mvm_8_1_16_1_core.
module tb_mvm_8_1_16_1_core;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  logic signed [15:0] amat [64];
  logic signed [15:0] xv   [8];
  logic signed [31:0] ev   [8];

  mvm_8_1_16_1_core_if bus ();

  mvm_8_1_16_1_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d (0x%h), expected %0d (0x%h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic load_matrix(input bit with_start);
    bus.loadMatrix = 1'b1;
    bus.start      = with_start;
    tick();
    bus.loadMatrix = 1'b0;
    bus.start      = 1'b0;
    for (int k = 0; k < 64; k++) begin
      bus.data_in = amat[k];
      tick();
    end
    bus.data_in = '0;
  endtask

  task automatic load_vector();
    bus.loadVector = 1'b1;
    tick();
    bus.loadVector = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.data_in = xv[k];
      tick();
    end
    bus.data_in = '0;
  endtask

  task automatic run_start(input string tag);
    int n;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk($sformatf("%s_done_early", tag), {31'd0, bus.done}, 32'd0);
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (bus.done) break;
    end
    chk($sformatf("%s_done_edge", tag), n, 32'd66);
    tick();
    chk($sformatf("%s_done_width", tag), {31'd0, bus.done}, 32'd0);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("%s_y%0d", tag, j), bus.data_out, ev[j]);
      tick();
    end
    chk($sformatf("%s_hold", tag), bus.data_out, ev[7]);
  endtask

  initial begin
    int hits;
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    bus.loadMatrix = 1'b0;
    bus.loadVector = 1'b0;
    bus.start      = 1'b0;
    bus.data_in    = '0;
    repeat (3) tick();
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_dout", bus.data_out, 32'd0);
    reset = 1'b0;
    tick();

    // Identity matrix passes x straight through.
    for (int k = 0; k < 64; k++) amat[k] = (k / 8 == k % 8) ? 16'sd1 : 16'sd0;
    xv = '{16'sd1, -16'sd2, 16'sd3, -16'sd4, 16'sd5, -16'sd6, 16'sd7, -16'sd8};
    ev = '{32'sd1, -32'sd2, 32'sd3, -32'sd4, 32'sd5, -32'sd6, 32'sd7, -32'sd8};
    load_matrix(1'b0);
    load_vector();
    run_start("ident");
    run_start("repeat");

    // Only x reloaded: doubled vector, same identity A.
    xv = '{16'sd2, -16'sd4, 16'sd6, -16'sd8, 16'sd10, -16'sd12, 16'sd14, -16'sd16};
    ev = '{32'sd2, -32'sd4, 32'sd6, -32'sd8, 32'sd10, -32'sd12, 32'sd14, -32'sd16};
    load_vector();
    run_start("x2");

    // 8 * (11585 * -11585) = -1073697800
    for (int k = 0; k < 64; k++) amat[k] = 16'sd11585;
    for (int k = 0; k < 8; k++) xv[k] = -16'sd11585;
    for (int k = 0; k < 8; k++) ev[k] = -32'sd1073697800;
    load_matrix(1'b0);
    load_vector();
    run_start("big");

    // Reset between load and start keeps A and x.
    reset = 1'b1;
    tick();
    chk("rstld_done", {31'd0, bus.done}, 32'd0);
    chk("rstld_dout", bus.data_out, 32'd0);
    reset = 1'b0;
    tick();
    run_start("after_rst");

    // Reset in the middle of COMPUTE suppresses done.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (30) tick();
    reset = 1'b1;
    tick();
    chk("rstc_done", {31'd0, bus.done}, 32'd0);
    chk("rstc_dout", bus.data_out, 32'd0);
    reset = 1'b0;
    hits  = 0;
    repeat (80) begin
      tick();
      if (bus.done) hits++;
    end
    chk("rstc_no_done", hits, 32'd0);
    run_start("post_rstc");

    // Overflow: 8 * 32767^2 = 8589410312.
    for (int k = 0; k < 64; k++) amat[k] = 16'sd32767;
    for (int k = 0; k < 8; k++) xv[k] = 16'sd32767;
`ifdef MVM_SATURATE_EN
    for (int k = 0; k < 8; k++) ev[k] = 32'sh7fffffff;
`else
    for (int k = 0; k < 8; k++) ev[k] = -32'sd524280;
`endif
    load_matrix(1'b0);
    load_vector();
    run_start("ovf");

    // loadMatrix beats a simultaneous start; old x is reused with new A.
    for (int k = 0; k < 64; k++) amat[k] = (k / 8 == k % 8) ? 16'sd1 : 16'sd0;
    for (int k = 0; k < 8; k++) ev[k] = 32'sd32767;
    load_matrix(1'b1);
    run_start("prio");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
